wb_unified_mem_arbiter: RTL and testbench

//  Shares one Wishbone slave port (unified code+data RAM) between the core's instruction and data buses.

---
 rtl/wb_unified_mem_arbiter_if.sv | 52 +++++
 rtl/wb_unified_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_unified_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_unified_mem_arbiter_if.sv
// Bundle of the instruction, data and unified-memory Wishbone signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding core/memory view.
interface wb_unified_mem_arbiter_if;
    logic        ib_cyc_i;
    logic        ib_stb_i;
    logic [31:0] ib_adr_i;
    logic [31:0] ib_dat_o;
    logic        ib_ack_o;
    logic        ib_err_o;

    logic        db_cyc_i;
    logic        db_stb_i;
    logic        db_we_i;
    logic [3:0]  db_sel_i;
    logic [31:0] db_adr_i;
    logic [31:0] db_dat_i;
    logic [31:0] db_dat_o;
    logic        db_ack_o;
    logic        db_err_o;

    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i;
    logic        m_err_i;

    logic [1:0]  grant_o;

    modport slave (
        input  ib_cyc_i, ib_stb_i, ib_adr_i,
        output ib_dat_o, ib_ack_o, ib_err_o,
        input  db_cyc_i, db_stb_i, db_we_i, db_sel_i, db_adr_i, db_dat_i,
        output db_dat_o, db_ack_o, db_err_o,
        output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        input  m_dat_i, m_ack_i, m_err_i,
        output grant_o
    );

    modport master (
        output ib_cyc_i, ib_stb_i, ib_adr_i,
        input  ib_dat_o, ib_ack_o, ib_err_o,
        output db_cyc_i, db_stb_i, db_we_i, db_sel_i, db_adr_i, db_dat_i,
        input  db_dat_o, db_ack_o, db_err_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        output m_dat_i, m_ack_i, m_err_i,
        input  grant_o
    );
endinterface

// File: rtl/wb_unified_mem_arbiter.sv
// Shares one unified-memory Wishbone port between the instruction and data buses,
// with bus locking per cycle and a per-transfer stall timeout that answers with an error.
module wb_unified_mem_arbiter #(
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    wb_unified_mem_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t          r_state;
    state_t          w_nextState;
    logic            r_lastGrantDb;
    logic [CW-1:0]   r_timeoutCnt;
    logic            r_timeoutPend;

    logic            w_reqIb;
    logic            w_reqDb;
    logic            w_mStb;
    logic            w_stall;
    logic            w_timeoutHit;
    logic            w_pendNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_lastGrantDb <= 1'b0;
            r_timeoutCnt  <= '0;
            r_timeoutPend <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_timeoutPend <= w_pendNext;
            if (r_state == IDLE && w_nextState != IDLE) begin
                r_lastGrantDb <= (w_nextState == OWN_D);
            end
            if (r_state == IDLE || bus.m_ack_i || bus.m_err_i) begin
                r_timeoutCnt <= '0;
            end else if (w_stall && r_timeoutCnt != {CW{1'b1}}) begin
                r_timeoutCnt <= r_timeoutCnt + 1'b1;
            end
        end
    end

    // While a timeout is pending the owner sees only the error and the slave sees the cycle dropped.
    always_comb begin
        w_nextState  = r_state;
        w_reqIb      = bus.ib_cyc_i & bus.ib_stb_i;
        w_reqDb      = bus.db_cyc_i & bus.db_stb_i;
        w_mStb       = 1'b0;
        bus.ib_dat_o = '0;
        bus.ib_ack_o = 1'b0;
        bus.ib_err_o = 1'b0;
        bus.db_dat_o = '0;
        bus.db_ack_o = 1'b0;
        bus.db_err_o = 1'b0;
        bus.m_cyc_o  = 1'b0;
        bus.m_stb_o  = 1'b0;
        bus.m_we_o   = 1'b0;
        bus.m_sel_o  = 4'h0;
        bus.m_adr_o  = '0;
        bus.m_dat_o  = '0;
        bus.grant_o  = 2'b00;

        case (r_state)
            IDLE: begin
                if (w_reqIb && w_reqDb) begin
                    if (DATA_PRIORITY != 0 || !r_lastGrantDb) begin
                        w_nextState = OWN_D;
                    end else begin
                        w_nextState = OWN_I;
                    end
                end else if (w_reqDb) begin
                    w_nextState = OWN_D;
                end else if (w_reqIb) begin
                    w_nextState = OWN_I;
                end
            end
            OWN_I: begin
                bus.grant_o  = 2'b01;
                bus.m_cyc_o  = bus.ib_cyc_i & ~r_timeoutPend;
                w_mStb       = bus.ib_stb_i & ~r_timeoutPend;
                bus.m_stb_o  = w_mStb;
                bus.m_sel_o  = 4'hF;
                bus.m_adr_o  = bus.ib_adr_i;
                bus.ib_dat_o = bus.m_dat_i;
                bus.ib_ack_o = bus.m_ack_i & ~bus.m_err_i & ~r_timeoutPend;
                bus.ib_err_o = bus.m_err_i | r_timeoutPend;
                if (r_timeoutPend || !bus.ib_cyc_i) begin
                    w_nextState = IDLE;
                end
            end
            OWN_D: begin
                bus.grant_o  = 2'b10;
                bus.m_cyc_o  = bus.db_cyc_i & ~r_timeoutPend;
                w_mStb       = bus.db_stb_i & ~r_timeoutPend;
                bus.m_stb_o  = w_mStb;
                bus.m_we_o   = bus.db_we_i;
                bus.m_sel_o  = bus.db_sel_i;
                bus.m_adr_o  = bus.db_adr_i;
                bus.m_dat_o  = bus.db_dat_i;
                bus.db_dat_o = bus.m_dat_i;
                bus.db_ack_o = bus.m_ack_i & ~bus.m_err_i & ~r_timeoutPend;
                bus.db_err_o = bus.m_err_i | r_timeoutPend;
                if (r_timeoutPend || !bus.db_cyc_i) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        w_stall      = (r_state != IDLE) & w_mStb & ~bus.m_ack_i & ~bus.m_err_i;
        w_timeoutHit = (TIMEOUT_CYCLES != 0) && w_stall && (r_timeoutCnt == CW'(TO_LAST));
        w_pendNext   = w_timeoutHit && !r_timeoutPend && (w_nextState != IDLE);
    end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Directed bench: dutA uses data priority with an 8-cycle timeout, dutB uses round-robin.
module tb_wb_unified_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_unified_mem_arbiter_if busA();
    wb_unified_mem_arbiter_if busB();

    wb_unified_mem_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    wb_unified_mem_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(64)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // Drives both masters of dutA in one call.
    task automatic applyStimulus(input logic ibCyc, input logic [31:0] ibAdr,
                                 input logic dbCyc, input logic dbWe, input logic [3:0] dbSel,
                                 input logic [31:0] dbAdr, input logic [31:0] dbDat);
        busA.ib_cyc_i = ibCyc;
        busA.ib_stb_i = ibCyc;
        busA.ib_adr_i = ibAdr;
        busA.db_cyc_i = dbCyc;
        busA.db_stb_i = dbCyc;
        busA.db_we_i  = dbWe;
        busA.db_sel_i = dbSel;
        busA.db_adr_i = dbAdr;
        busA.db_dat_i = dbDat;
    endtask

    initial begin
        logic [1:0] expGrant [4];
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        busA.m_dat_i = '0; busA.m_ack_i = 1'b0; busA.m_err_i = 1'b0;
        busB.ib_cyc_i = 1'b0; busB.ib_stb_i = 1'b0; busB.ib_adr_i = '0;
        busB.db_cyc_i = 1'b0; busB.db_stb_i = 1'b0; busB.db_we_i = 1'b0;
        busB.db_sel_i = 4'h0; busB.db_adr_i = '0; busB.db_dat_i = '0;
        busB.m_dat_i = '0; busB.m_ack_i = 1'b0; busB.m_err_i = 1'b0;

        tick();
        checkOutput("reset_grant", {30'd0, busA.grant_o}, 32'd0);
        checkOutput("reset_m_cyc", {31'd0, busA.m_cyc_o}, 32'd0);
        checkOutput("reset_m_sel", {28'd0, busA.m_sel_o}, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] single fetch");
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        checkOutput("fetch_arb_latency", {30'd0, busA.grant_o}, 32'd0);
        tick();
        checkOutput("fetch_grant", {30'd0, busA.grant_o}, 32'd1);
        checkOutput("fetch_m_adr", busA.m_adr_o, 32'h100);
        checkOutput("fetch_m_sel", {28'd0, busA.m_sel_o}, 32'hF);
        checkOutput("fetch_m_we", {31'd0, busA.m_we_o}, 32'd0);
        checkOutput("fetch_ack_early", {31'd0, busA.ib_ack_o}, 32'd0);
        busA.m_ack_i = 1'b1; busA.m_dat_i = 32'hDEADBEEF;
        settle();
        checkOutput("fetch_ack", {31'd0, busA.ib_ack_o}, 32'd1);
        checkOutput("fetch_dat", busA.ib_dat_o, 32'hDEADBEEF);
        checkOutput("fetch_db_dat", busA.db_dat_o, 32'd0);
        tick();
        busA.m_ack_i = 1'b0;
        applyStimulus(1'b0, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        checkOutput("fetch_release_m_cyc", {31'd0, busA.m_cyc_o}, 32'd0);
        tick();
        checkOutput("fetch_idle", {30'd0, busA.grant_o}, 32'd0);

        $display("[TB] data priority conflict");
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        tick();
        checkOutput("conflict_grant_d", {30'd0, busA.grant_o}, 32'd2);
        checkOutput("conflict_m_adr", busA.m_adr_o, 32'h300);
        busA.m_ack_i = 1'b1; busA.m_dat_i = 32'h12345678;
        settle();
        checkOutput("conflict_db_ack", {31'd0, busA.db_ack_o}, 32'd1);
        checkOutput("conflict_db_dat", busA.db_dat_o, 32'h12345678);
        checkOutput("conflict_ib_ack", {31'd0, busA.ib_ack_o}, 32'd0);
        checkOutput("conflict_ib_dat", busA.ib_dat_o, 32'd0);
        tick();
        busA.m_ack_i = 1'b0;
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 4'hF, 32'h300, 32'h0);
        tick();
        checkOutput("conflict_idle_gap", {30'd0, busA.grant_o}, 32'd0);
        tick();
        checkOutput("conflict_grant_i", {30'd0, busA.grant_o}, 32'd1);
        checkOutput("conflict_i_adr", busA.m_adr_o, 32'h200);
        busA.m_ack_i = 1'b1;
        settle();
        checkOutput("conflict_i_ack", {31'd0, busA.ib_ack_o}, 32'd1);
        tick();
        busA.m_ack_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        $display("[TB] data write with error beat");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h1000, 32'h1);
        tick();
        checkOutput("write_m_we", {31'd0, busA.m_we_o}, 32'd1);
        checkOutput("write_m_sel", {28'd0, busA.m_sel_o}, 32'hF);
        checkOutput("write_m_adr", busA.m_adr_o, 32'h1000);
        checkOutput("write_m_dat", busA.m_dat_o, 32'h1);
        busA.m_ack_i = 1'b1; busA.m_err_i = 1'b1;
        settle();
        checkOutput("errwins_ack", {31'd0, busA.db_ack_o}, 32'd0);
        checkOutput("errwins_err", {31'd0, busA.db_err_o}, 32'd1);
        tick();
        busA.m_err_i = 1'b0;
        settle();
        checkOutput("write_ack", {31'd0, busA.db_ack_o}, 32'd1);
        checkOutput("write_lock_grant", {30'd0, busA.grant_o}, 32'd2);
        tick();
        busA.m_ack_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        $display("[TB] timeout");
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            checkOutput("timeout_stall_err", {31'd0, busA.ib_err_o}, 32'd0);
            checkOutput("timeout_stall_stb", {31'd0, busA.m_stb_o}, 32'd1);
            tick();
        end
        checkOutput("timeout_err", {31'd0, busA.ib_err_o}, 32'd1);
        checkOutput("timeout_m_cyc", {31'd0, busA.m_cyc_o}, 32'd0);
        checkOutput("timeout_m_stb", {31'd0, busA.m_stb_o}, 32'd0);
        tick();
        checkOutput("timeout_idle", {30'd0, busA.grant_o}, 32'd0);
        checkOutput("timeout_err_once", {31'd0, busA.ib_err_o}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        busA.m_ack_i = 1'b1;
        settle();
        checkOutput("late_ack_ib", {31'd0, busA.ib_ack_o}, 32'd0);
        checkOutput("late_ack_db", {31'd0, busA.db_ack_o}, 32'd0);
        tick();
        busA.m_ack_i = 1'b0;
        checkOutput("late_ack_grant", {30'd0, busA.grant_o}, 32'd0);

        $display("[TB] round robin");
        expGrant[0] = 2'b10; expGrant[1] = 2'b01; expGrant[2] = 2'b10; expGrant[3] = 2'b01;
        busB.ib_cyc_i = 1'b1; busB.ib_stb_i = 1'b1; busB.ib_adr_i = 32'h500;
        busB.db_cyc_i = 1'b1; busB.db_stb_i = 1'b1; busB.db_adr_i = 32'h600;
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("rr_grant", {30'd0, busB.grant_o}, {30'd0, expGrant[i]});
            busB.m_ack_i = 1'b1;
            tick();
            busB.m_ack_i = 1'b0;
            if (expGrant[i][1]) begin
                busB.db_cyc_i = 1'b0; busB.db_stb_i = 1'b0;
            end else begin
                busB.ib_cyc_i = 1'b0; busB.ib_stb_i = 1'b0;
            end
            tick();
            checkOutput("rr_idle_gap", {30'd0, busB.grant_o}, 32'd0);
            busB.ib_cyc_i = 1'b1; busB.ib_stb_i = 1'b1;
            busB.db_cyc_i = 1'b1; busB.db_stb_i = 1'b1;
            tick();
        end
        busB.ib_cyc_i = 1'b0; busB.ib_stb_i = 1'b0;
        busB.db_cyc_i = 1'b0; busB.db_stb_i = 1'b0;

        $display("[TB] async reset mid transfer");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
        tick();
        tick();
        checkOutput("rst_pre_grant", {30'd0, busA.grant_o}, 32'd2);
        busA.m_ack_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_m_cyc", {31'd0, busA.m_cyc_o}, 32'd0);
        checkOutput("rst_db_ack", {31'd0, busA.db_ack_o}, 32'd0);
        checkOutput("rst_grant", {30'd0, busA.grant_o}, 32'd0);
        busA.m_ack_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_regrant", {30'd0, busA.grant_o}, 32'd2);
        checkOutput("rst_regrant_adr", busA.m_adr_o, 32'h700);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
